// File: rtl/xinlv_uart_tx.sv
// Heart-rate UART reporter: converts an 8-bit bpm value to three ASCII decimal digits
// plus CR LF and sends the 5-byte frame as 8N1 using an internal baud counter.
module xinlv_uart_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned BPS_DIV  = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic [7:0] xinlv,
    output logic       data_tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam logic [CNT_W-1:0] BaudMax = CNT_W'(BPS_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StConvH,
        StConvT,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       val_q, val_d;
    logic [1:0]       h_q, h_d;
    logic [3:0]       t_q, t_d;
    logic [3:0]       o_q, o_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             data_tx_q, data_tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0]       cur_byte;
    logic             baud_wrap;

    assign baud_wrap = (baud_cnt_q == BaudMax);

    always_comb begin
        unique case (idx_q)
            3'd0:    cur_byte = 8'h30 | {6'b0, h_q};
            3'd1:    cur_byte = 8'h30 | {4'b0, t_q};
            3'd2:    cur_byte = 8'h30 | {4'b0, o_q};
            3'd3:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        h_d        = h_q;
        t_d        = t_q;
        o_d        = o_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        data_tx_d  = 1'b1;

        unique case (state_q)
            StIdle: begin
                // The cycle showing done still refuses a request; the next one accepts.
                if (send_req && !done_q) begin
                    val_d   = xinlv;
                    h_d     = '0;
                    t_d     = '0;
                    o_d     = '0;
                    busy_d  = 1'b1;
                    state_d = StConvH;
                end
            end
            StConvH: begin
                if (val_q >= 8'd100) begin
                    val_d = val_q - 8'd100;
                    h_d   = h_q + 2'd1;
                end else begin
                    state_d = StConvT;
                end
            end
            StConvT: begin
                if (val_q >= 8'd10) begin
                    val_d = val_q - 8'd10;
                    t_d   = t_q + 4'd1;
                end else begin
                    o_d     = val_q[3:0];
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shift_d    = cur_byte;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                state_d    = StStart;
            end
            StStart: begin
                data_tx_d = 1'b0;
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    state_d    = StData;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                data_tx_d = shift_q[0];
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (idx_q < 3'd4) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StLoad;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            val_q      <= '0;
            h_q        <= '0;
            t_q        <= '0;
            o_q        <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_tx_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            h_q        <= h_d;
            t_q        <= t_d;
            o_q        <= o_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_tx_q  <= data_tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign data_tx = data_tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_xinlv_uart_tx.sv
// Bench for xinlv_uart_tx: directed frame table decoded by an independent 8N1 receiver,
// plus hand-written back-to-back and mid-frame reset sequences.
module tb_xinlv_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] xinlv = 8'd0;
    logic       data_tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    xinlv_uart_tx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .send_req(send_req),
        .xinlv   (xinlv),
        .data_tx (data_tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         start;
        int         blen;
        bit         poke;
    } vec_t;

    vec_t tbl[7];

    logic [7:0] rx_bytes[8];
    int         rx_n;
    int         start_k;
    int         busy_len;
    int         done_seen;
    int         stop_err;
    int         glitch;
    logic       end_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called just after a negedge; the following posedge samples the request.
    task automatic req(input logic [7:0] v);
        xinlv    = v;
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    // Index k is the negedge after the k-th posedge following the accepting edge.
    task automatic capture(input bit poke);
        bit         in_fr;
        int         sb;
        int         rel;
        logic       prev;
        logic [7:0] shreg;
        rx_n = 0; start_k = -1; busy_len = -1; done_seen = 0;
        stop_err = 0; glitch = 0; end_done = 1'b0;
        in_fr = 1'b0; sb = 0; prev = 1'b1; shreg = 8'h00;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk);
            if (poke) begin
                send_req = ((k % 50) == 49);
                if (k == 200) xinlv = 8'd5;
            end
            if (!busy) begin
                busy_len = k;
                end_done = done;
                break;
            end
            if (done) done_seen++;
            if (!in_fr) begin
                if (!data_tx) begin
                    in_fr = 1'b1;
                    sb    = k;
                    if (start_k < 0) start_k = k;
                end
            end else begin
                rel = k - sb;
                if (data_tx !== prev && (rel % 10) != 0) glitch++;
                if (rel == 5 && data_tx !== 1'b0) stop_err++;
                if (rel >= 15 && rel <= 85 && (rel % 10) == 5) shreg = {data_tx, shreg[7:1]};
                if (rel == 95) begin
                    if (data_tx !== 1'b1) stop_err++;
                    if (rx_n < 8) rx_bytes[rx_n] = shreg;
                    rx_n++;
                    in_fr = 1'b0;
                end
            end
            prev = data_tx;
        end
        send_req = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int st, input int bl);
        chk({tag, "_nbytes"}, rx_n, 5);
        chk({tag, "_byte0"}, int'(rx_bytes[0]), int'(b0));
        chk({tag, "_byte1"}, int'(rx_bytes[1]), int'(b1));
        chk({tag, "_byte2"}, int'(rx_bytes[2]), int'(b2));
        chk({tag, "_byte3"}, int'(rx_bytes[3]), 32'h0D);
        chk({tag, "_byte4"}, int'(rx_bytes[4]), 32'h0A);
        chk({tag, "_start"}, start_k, st);
        chk({tag, "_busylen"}, busy_len, bl);
        chk({tag, "_done_end"}, int'(end_done), 1);
        chk({tag, "_done_early"}, done_seen, 0);
        chk({tag, "_framing"}, stop_err, 0);
        chk({tag, "_glitch"}, glitch, 0);
    endtask

    initial begin
        int bad;

        // Busy spans conversion (h+1)+(t+1) plus five 101-clock byte slots.
        tbl[0] = '{8'd72,  8'h30, 8'h37, 8'h32, 11, 514, 1'b0};
        tbl[1] = '{8'd0,   8'h30, 8'h30, 8'h30,  4, 507, 1'b0};
        tbl[2] = '{8'd255, 8'h32, 8'h35, 8'h35, 11, 514, 1'b0};
        tbl[3] = '{8'd199, 8'h31, 8'h39, 8'h39, 14, 517, 1'b0};
        tbl[4] = '{8'd9,   8'h30, 8'h30, 8'h39,  4, 507, 1'b0};
        tbl[5] = '{8'd10,  8'h30, 8'h31, 8'h30,  5, 508, 1'b0};
        tbl[6] = '{8'd88,  8'h30, 8'h38, 8'h38, 12, 515, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_held_data_tx", int'(data_tx), 1);
        chk("rst_held_busy", int'(busy), 0);
        chk("rst_held_done", int'(done), 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_after_reset", bad, 0);

        for (int i = 0; i < 7; i++) begin
            req(tbl[i].val);
            capture(tbl[i].poke);
            verify($sformatf("frame%0d_v%0d", i, tbl[i].val), tbl[i].b0, tbl[i].b1, tbl[i].b2,
                   tbl[i].start, tbl[i].blen);
            @(negedge clk);
            chk($sformatf("frame%0d_done_1cyc", i), int'(done), 0);
            if (tbl[i].poke) begin
                bad = 0;
                for (int j = 0; j < 200; j++) begin
                    @(negedge clk);
                    if (busy !== 1'b0 || done !== 1'b0 || data_tx !== 1'b1) bad++;
                end
                chk("no_queued_frame", bad, 0);
            end
            repeat (3) @(negedge clk);
        end

        // Back-to-back: request in the done cycle is refused, one cycle later accepted.
        req(8'd0);
        capture(1'b0);
        verify("b2b_first", 8'h30, 8'h30, 8'h30, 4, 507);
        send_req = 1'b1;
        xinlv    = 8'd100;
        @(negedge clk);
        chk("b2b_done_cycle_ignored", int'(busy), 0);
        @(negedge clk);
        send_req = 1'b0;
        capture(1'b0);
        verify("b2b_second", 8'h31, 8'h30, 8'h30, 5, 508);
        repeat (5) @(negedge clk);

        // Reset during the data bits of the third byte.
        req(8'd72);
        repeat (250) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_data_tx", int'(data_tx), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int j = 0; j < 150; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || data_tx !== 1'b1) bad++;
        end
        chk("abort_quiet", bad, 0);
        req(8'd60);
        capture(1'b0);
        verify("after_abort", 8'h30, 8'h36, 8'h30, 10, 513);
        @(negedge clk);
        chk("after_abort_done_1cyc", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
